// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: turns one decoded load/store into a word-aligned
// valid/ready memory transaction and returns a formatted, error-qualified response.
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            load_inst,
  input  logic [3:0]            store_mask,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t state, state_n;

  logic                  is_load_in, is_store_in, is_half, is_word, req_ok;
  logic [2:0]            ld_q;
  logic [1:0]            off_q;
  logic [7:0]            cnt;
  logic [DATA_WIDTH-1:0] shifted, load_fmt;

  assign req_ready     = (state == S_IDLE);
  assign resp_valid    = (state == S_RESP);
  assign mem_req_valid = (state == S_REQ);

  always_comb begin
    is_load_in  = (store_mask == 4'b0000) &&
                  (load_inst inside {3'b001, 3'b010, 3'b011, 3'b100, 3'b101});
    is_store_in = (load_inst == 3'b000) &&
                  (store_mask inside {4'b0001, 4'b0011, 4'b1111});
    is_half     = (is_load_in && (load_inst == 3'b010 || load_inst == 3'b101)) ||
                  (is_store_in && store_mask == 4'b0011);
    is_word     = (is_load_in && load_inst == 3'b011) ||
                  (is_store_in && store_mask == 4'b1111);
    req_ok      = (is_load_in || is_store_in) &&
                  !(is_half && addr[0]) &&
                  !(is_word && addr[1:0] != 2'b00);
  end

  // Byte lane selected by the captured offset, then sign/zero extended by load type.
  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_fmt = '0;
    case (ld_q)
      3'b001:  load_fmt = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b010:  load_fmt = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b011:  load_fmt = shifted;
      3'b100:  load_fmt = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_fmt = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_fmt = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (req_valid) state_n = req_ok ? S_REQ : S_RESP;
      S_REQ:  if (mem_req_ready) state_n = mem_we ? S_RESP : S_WAIT;
      S_WAIT: if (mem_rvalid || cnt == TMO_LAST) state_n = S_RESP;
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Memory-side fields are captured only for accesses that will actually be issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_data <= '0;
      resp_err  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
      ld_q      <= 3'b000;
      off_q     <= 2'b00;
      cnt       <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            resp_data <= '0;
            resp_err  <= !req_ok;
            if (req_ok) begin
              mem_we    <= is_store_in;
              mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wstrb <= is_store_in ? (store_mask << addr[1:0]) : 4'b0000;
              mem_wdata <= is_store_in ? (store_data << {addr[1:0], 3'b000}) : '0;
              ld_q      <= load_inst;
              off_q     <= addr[1:0];
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready && !mem_we) cnt <= 8'd0;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            resp_data <= load_fmt;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == TMO_LAST) resp_err <= 1'b1;
          end
        end
        S_RESP: begin
          resp_data <= '0;
          resp_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
